rst_seq_ctrl: RTL and testbench
===============================

// Module: rst_seq_ctrl
// PURPOSE
//  Reset sequencer. Generates the active-low, asynchronously asserted reset_l inputs consumed by
//  downstream flop blocks (async clear on negedge reset_l).
//  Asserts all reset outputs asynchronously and synchronises deassertion to clk. Releases the
//  NUM_OUT reset domains one at a time, in index order, after a hold period.
//  Also runs a software-requested reset sequence with a completion acknowledge.
// PARAMETERS
//  SYNC_STAGES  2   deassertion synchroniser depth, >=2
//  NUM_OUT      3   number of sequenced reset outputs, >=1
//  HOLD_CYCLES  8   cycles all outputs stay asserted after synchronised release, >=1
//  STAGGER      4   cycles between successive output releases, >=1
//  CNT_W        8   counter width; must hold max(HOLD_CYCLES,STAGGER)-1
// PORTS
//  clk          in   1                 clock
//  reset_l      in   1                 asynchronous, active-low master reset
//  sw_rst_req   in   1                 software reset request, sampled only in RUN
//  sw_rst_ack   out  1                 one-cycle pulse: software-initiated sequence complete
//  rst_out_l    out  NUM_OUT           sequenced active-low resets, driven directly from flops
//  busy         out  1                 1 whenever state != RUN
//  state        out  2                 debug: 0=HOLD 1=RELEASE 2=RUN
// BEHAVIOUR
//  Reset values (reset_l=0, applied asynchronously):
//   - sync chain=0, rst_out_l=0, state=HOLD, cnt=0, idx=0, sw_pend=0, sw_rst_ack=0, busy=1.
//  Sync chain: shifts in 1 each edge while reset_l=1; sync_ok = last stage.
//   - sync_ok first reads 1 after edge SYNC_STAGES following reset_l rise.
//  HOLD:
//   - When sync_ok=0: cnt held at 0.
//   - When sync_ok=1: cnt++ each edge.
//   - At the edge with cnt==HOLD_CYCLES-1: rst_out_l[0]<=1, cnt<=0.
//     - If NUM_OUT==1: state<=RUN.
//     - Otherwise: state<=RELEASE, idx<=1.
//  RELEASE:
//   - cnt++ each edge.
//   - At the edge with cnt==STAGGER-1: rst_out_l[idx]<=1, cnt<=0, idx++.
//   - If idx==NUM_OUT-1 at that edge: state<=RUN.
//  Release timing: rst_out_l[i] rises at edge SYNC_STAGES+HOLD_CYCLES+i*STAGGER after reset_l
//   rise (edges counted from 1).
//   - Released outputs stay 1 until the next reset; order is strictly ascending index.
//  RUN:
//   - On an edge with sw_rst_req=1: rst_out_l<=0 (all bits), state<=HOLD, cnt<=0, sw_pend<=1.
//   - The sync chain is already 1, so HOLD counts from the next edge.
//   - Release follows the same schedule, relative to the request edge e:
//     out[i] rises at e+HOLD_CYCLES+i*STAGGER.
//  sw_rst_ack:
//   - Registered 1 for exactly one cycle after the edge that enters RUN with sw_pend=1.
//   - sw_pend clears on that same edge.
//   - Never pulses for a reset_l-initiated sequence.
//  sw_rst_req outside RUN:
//   - Ignored: no restart, no ack, not queued. Level-held requests re-trigger each time RUN is
//     reached.
//  Reset mid-operation:
//   - reset_l low in any state (including during a sw sequence) immediately clears everything
//     to the reset values.
//   - sw_pend is lost, so no ack is issued. The full sequence restarts on reset_l rise.
//  Glitches: a reset_l low pulse shorter than one clk period still asserts all outputs and
//   restarts the sequence.
//  No combinational path from any input to rst_out_l other than the async clear.
// TESTING
//  1. reset_l low 5 cycles, release before edge 1 (defaults) -> rst_out_l=000 until edge 10;
//     then 001 at edge 10, 011 at edge 14, 111 at edge 18; busy=0 and state=2 from edge 18;
//     sw_rst_ack stays 0.
//  2. In RUN, 1-cycle sw_rst_req at edge e -> rst_out_l=000 after e; 001/011/111 at
//     e+8/e+12/e+16; sw_rst_ack=1 only in the cycle after e+16.
//  3. sw_rst_req held high during RELEASE -> no restart until RUN is entered; if still high at
//     the next edge, a new sequence starts with a single ack at its end.
//  4. reset_l pulled low mid-sequence (rst_out_l=011) and mid-sw-sequence -> rst_out_l=000
//     with no clock edge; timing restarts per test 1; no sw_rst_ack ever.
//  5. Sub-cycle reset_l low glitch while in RUN -> outputs drop asynchronously; full sequence
//     repeats.
//  6. NUM_OUT=1, HOLD_CYCLES=1, STAGGER=1 -> rst_out_l rises at edge 3; RUN at edge 3;
//     sw request at e -> release at e+1 with ack the cycle after e+1.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq_ctrl
//  Description : Reset sequencer.
//                - Asserts every downstream active-low reset asynchronously.
//                - Synchronises release of the master reset to clk.
//                - Releases NUM_OUT reset domains one at a time, in
//                  ascending index order, after a hold period.
//                - Runs a software-requested reset sequence that ends with
//                  a one-cycle acknowledge.
//  Ports       : clk         - clock
//                reset_l     - asynchronous, active-low master reset
//                sw_rst_req  - software reset request (honoured only in RUN)
//                sw_rst_ack  - one-cycle pulse when a sw sequence completes
//                rst_out_l   - sequenced active-low resets (flop outputs)
//                busy        - high whenever the sequencer is not in RUN
//                state       - debug view: 0=HOLD 1=RELEASE 2=RUN
//  Revision    : 1.0  initial release
// ============================================================================
module rst_seq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGGER     = 4,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic               sw_rst_req,
    output logic               sw_rst_ack,
    output logic [NUM_OUT-1:0] rst_out_l,
    output logic               busy,
    output logic [1:0]         state
);

    // A single-output build still needs a 1-bit index register.
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_ok;

    state_t             cur_state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic               sw_pend;
    logic               sw_pend_next;
    logic               ack_next;
    logic [NUM_OUT-1:0] out_next;

    // Deassertion synchroniser: asserts with reset_l, fills with ones after.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_chain[SYNC_STAGES-1];

    // Every sequencer flop clears asynchronously, so rst_out_l drops without
    // waiting for a clock edge and any pending sw request is discarded.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cur_state  <= ST_HOLD;
            cnt        <= '0;
            idx        <= '0;
            sw_pend    <= 1'b0;
            sw_rst_ack <= 1'b0;
            rst_out_l  <= '0;
        end else begin
            cur_state  <= next_state;
            cnt        <= cnt_next;
            idx        <= idx_next;
            sw_pend    <= sw_pend_next;
            sw_rst_ack <= ack_next;
            rst_out_l  <= out_next;
        end
    end

    always_comb begin
        next_state   = cur_state;
        cnt_next     = cnt;
        idx_next     = idx;
        sw_pend_next = sw_pend;
        ack_next     = 1'b0;
        out_next     = rst_out_l;

        case (cur_state)
            ST_HOLD: begin
                if (!sync_ok) begin
                    cnt_next = '0;
                end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    out_next[0] = 1'b1;
                    cnt_next    = '0;
                    if (NUM_OUT == 1) begin
                        next_state   = ST_RUN;
                        ack_next     = sw_pend;
                        sw_pend_next = 1'b0;
                    end else begin
                        next_state = ST_RELEASE;
                        idx_next   = IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (cnt == CNT_W'(STAGGER - 1)) begin
                    // Decoded compare avoids a variable part-select that
                    // could fall outside rst_out_l for small NUM_OUT.
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (idx == IDX_W'(i)) begin
                            out_next[i] = 1'b1;
                        end
                    end
                    cnt_next = '0;
                    idx_next = idx + IDX_W'(1);
                    if (idx == IDX_W'(NUM_OUT - 1)) begin
                        next_state   = ST_RUN;
                        ack_next     = sw_pend;
                        sw_pend_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            ST_RUN: begin
                // Sync chain is already full, so HOLD counts from the next edge.
                if (sw_rst_req) begin
                    out_next     = '0;
                    next_state   = ST_HOLD;
                    cnt_next     = '0;
                    idx_next     = '0;
                    sw_pend_next = 1'b1;
                end
            end

            default: begin
                // Unused encoding: fall back to a fully asserted hold.
                out_next   = '0;
                next_state = ST_HOLD;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    assign busy  = (cur_state != ST_RUN);
    assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rst_seq_ctrl
//  Description : Self-checking bench for rst_seq_ctrl. Stimulus pushes the
//                expected output events (edge number, rst_out_l, ack, state)
//                into a queue; a monitor pops one entry whenever rst_out_l
//                changes or sw_rst_ack is high. A second small instance
//                covers the single-output, minimum-timing configuration.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rst_seq_ctrl;

    localparam int SYNC    = 2;
    localparam int N       = 3;
    localparam int HOLD    = 8;
    localparam int STAG    = 4;
    localparam int HW_BASE = SYNC + HOLD;

    typedef struct {
        int           edge_no;
        logic [N-1:0] out;
        logic         ack;
        logic [1:0]   st;
    } ev_t;

    logic         clk = 1'b0;
    logic         reset_l;
    logic         sw_rst_req;
    logic         sw_rst_ack;
    logic [N-1:0] rst_out_l;
    logic         busy;
    logic [1:0]   state;

    logic         reset_l1;
    logic         sw_rst_req1;
    logic         sw_rst_ack1;
    logic [0:0]   rst_out_l1;
    logic         busy1;
    logic [1:0]   state1;

    int  edge_cnt = 0;
    int  run_from = 32'h4000_0000;
    ev_t exp_q[$];
    int  mon_checks  = 0;
    int  mon_errors  = 0;
    int  stim_checks = 0;
    int  stim_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    rst_seq_ctrl #(
        .SYNC_STAGES(SYNC), .NUM_OUT(N), .HOLD_CYCLES(HOLD), .STAGGER(STAG), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_l(reset_l), .sw_rst_req(sw_rst_req), .sw_rst_ack(sw_rst_ack),
        .rst_out_l(rst_out_l), .busy(busy), .state(state)
    );

    rst_seq_ctrl #(
        .SYNC_STAGES(2), .NUM_OUT(1), .HOLD_CYCLES(1), .STAGGER(1), .CNT_W(4)
    ) dut1 (
        .clk(clk), .reset_l(reset_l1), .sw_rst_req(sw_rst_req1), .sw_rst_ack(sw_rst_ack1),
        .rst_out_l(rst_out_l1), .busy(busy1), .state(state1)
    );

    // ---------------- reference model: event schedule ----------------
    // Output i of a sequence that starts after edge e0 rises at e0+base+i*STAG.
    task automatic push_seq(input int e0, input int base, input bit sw);
        ev_t          ev;
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[i]       = 1'b1;
            ev.edge_no = e0 + base + i * STAG;
            ev.out     = v;
            ev.ack     = sw && (i == N - 1);
            ev.st      = (i == N - 1) ? 2'd2 : 2'd1;
            exp_q.push_back(ev);
        end
        run_from = e0 + base + (N - 1) * STAG + 1;
    endtask

    task automatic push_sw(input int e);
        ev_t ev;
        ev.edge_no = e;
        ev.out     = '0;
        ev.ack     = 1'b0;
        ev.st      = 2'd0;
        exp_q.push_back(ev);
        push_seq(e, HOLD, 1'b1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        stim_checks++;
        if (act !== exp) begin
            stim_errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [N-1:0] prev;
        ev_t          ev;
        prev = '0;
        forever begin
            @(negedge clk or negedge reset_l);
            if (!reset_l) begin
                prev = '0;
            end else if (clk == 1'b0) begin
                while (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
                    mon_checks++;
                    mon_errors++;
                    $display("FAIL missed_event: out=%b expected at edge %0d, not seen by edge %0d",
                             exp_q[0].out, exp_q[0].edge_no, edge_cnt);
                    void'(exp_q.pop_front());
                end
                if (rst_out_l !== prev || sw_rst_ack !== 1'b0) begin
                    mon_checks++;
                    if (exp_q.size() == 0) begin
                        mon_errors++;
                        $display("FAIL unexpected_event: edge %0d out=%b ack=%b, required no change",
                                 edge_cnt, rst_out_l, sw_rst_ack);
                    end else begin
                        ev = exp_q.pop_front();
                        if (ev.edge_no != edge_cnt || rst_out_l !== ev.out || sw_rst_ack !== ev.ack ||
                            state !== ev.st || busy !== (ev.st != 2'd2)) begin
                            mon_errors++;
                            $display("FAIL event: got edge=%0d out=%b ack=%b state=%0d busy=%b, required edge=%0d out=%b ack=%b state=%0d busy=%b",
                                     edge_cnt, rst_out_l, sw_rst_ack, state, busy,
                                     ev.edge_no, ev.out, ev.ack, ev.st, (ev.st != 2'd2));
                        end
                    end
                    prev = rst_out_l;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int e;
        int op;
        int len;
        reset_l     = 1'b0;
        sw_rst_req  = 1'b0;
        reset_l1    = 1'b0;
        sw_rst_req1 = 1'b0;

        // Single-output, HOLD=1, STAGGER=1 instance.
        repeat (3) @(posedge clk);
        #1;
        chk("dut1_reset_out", 32'(rst_out_l1), 32'd0);
        chk("dut1_reset_busy", 32'(busy1), 32'd1);
        reset_l1 = 1'b1;
        @(posedge clk); #1;
        chk("dut1_e1_out", 32'(rst_out_l1), 32'd0);
        @(posedge clk); #1;
        chk("dut1_e2_out", 32'(rst_out_l1), 32'd0);
        chk("dut1_e2_state", 32'(state1), 32'd0);
        @(posedge clk); #1;
        chk("dut1_e3_out", 32'(rst_out_l1), 32'd1);
        chk("dut1_e3_state", 32'(state1), 32'd2);
        chk("dut1_e3_busy", 32'(busy1), 32'd0);
        chk("dut1_e3_ack", 32'(sw_rst_ack1), 32'd0);
        @(posedge clk); #1;
        sw_rst_req1 = 1'b1;
        @(posedge clk); #1;
        sw_rst_req1 = 1'b0;
        chk("dut1_sw_drop_out", 32'(rst_out_l1), 32'd0);
        chk("dut1_sw_drop_ack", 32'(sw_rst_ack1), 32'd0);
        @(posedge clk); #1;
        chk("dut1_sw_rel_out", 32'(rst_out_l1), 32'd1);
        chk("dut1_sw_ack", 32'(sw_rst_ack1), 32'd1);
        chk("dut1_sw_state", 32'(state1), 32'd2);
        @(posedge clk); #1;
        chk("dut1_ack_one_cycle", 32'(sw_rst_ack1), 32'd0);

        // Main instance: reset state, then power-on sequence.
        chk("reset_out", 32'(rst_out_l), 32'd0);
        chk("reset_ack", 32'(sw_rst_ack), 32'd0);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_state", 32'(state), 32'd0);
        k = edge_cnt;
        reset_l = 1'b1;
        push_seq(k, HW_BASE, 1'b0);
        while (edge_cnt < run_from + 1) @(posedge clk);
        #1;
        chk("run_busy", 32'(busy), 32'd0);
        chk("run_state", 32'(state), 32'd2);

        for (int it = 0; it < 45; it++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 4) begin
                repeat ($urandom_range(0, 25)) @(posedge clk);
                #1;
                sw_rst_req = 1'b1;
                e = edge_cnt + 1;
                if (e >= run_from) push_sw(e);
                @(posedge clk); #1;
                sw_rst_req = 1'b0;
            end else if (op <= 6) begin
                len = int'($urandom_range(2, 40));
                sw_rst_req = 1'b1;
                for (int j = 0; j < len; j++) begin
                    e = edge_cnt + 1;
                    if (e >= run_from) push_sw(e);
                    @(posedge clk); #1;
                end
                sw_rst_req = 1'b0;
            end else if (op <= 8) begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #1;
                reset_l = 1'b0;
                #1;
                chk("async_out", 32'(rst_out_l), 32'd0);
                chk("async_ack", 32'(sw_rst_ack), 32'd0);
                chk("async_busy", 32'(busy), 32'd1);
                chk("async_state", 32'(state), 32'd0);
                exp_q.delete();
                run_from = 32'h4000_0000;
                if (op == 8) begin
                    #2;   // sub-cycle glitch, released before the next edge
                end else begin
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1;
                end
                k = edge_cnt;
                reset_l = 1'b1;
                push_seq(k, HW_BASE, 1'b0);
            end else begin
                repeat ($urandom_range(1, 30)) @(posedge clk);
                #1;
            end
        end

        for (int w = 0; w < 300 && exp_q.size() != 0; w++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 mon_checks + stim_checks, mon_errors + stim_errors);
        $finish;
    end

endmodule
`default_nettype wire
